// File: rtl/uc_timing_rx.sv
// uc_timing_rx: FPGA-side capture and checker for the microcontroller slow-clock timing interface.
// Define UC_RX_LOS_EN to build the loss-of-signal watchdog; otherwise los is tied low.
module uc_timing_rx #(
  parameter int SlowClocksPerSecond = 10000,
  parameter int TickW               = $clog2(SlowClocksPerSecond + 1),
  parameter int LosTimeout          = 3840
) (
  input  logic             clk_tf,
  input  logic             tf_reset_l,
  input  logic             uc_slow_clock,
  input  logic             uc_pps_next,
  input  logic             uc_stop_next,
  input  logic             uc_stop_done,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [TickW-1:0] rpt_ticks,
  output logic             rpt_stop_seen,
  output logic [TickW-1:0] rpt_stop_tick,
  output logic [3:0]       rpt_err,
  output logic             locked,
  output logic             los
);

  typedef enum logic {S_hunt, S_track} state_t;

  localparam logic [TickW-1:0] TicksFull = TickW'(SlowClocksPerSecond);
  localparam logic [TickW-1:0] TickLast  = TickW'(SlowClocksPerSecond - 1);

  if (SlowClocksPerSecond < 2 || LosTimeout < 2) begin : g_bad_params
    $error("uc_timing_rx: SlowClocksPerSecond and LosTimeout must be at least 2");
  end

  // Synchronizer lanes are ordered {done, stop, pps, clock}.
  logic [3:0] sync_a, sync_b;
  logic       clk_dly;
  logic       s_clk, s_pps, s_stop, s_done;
  logic       tick_ev;

  assign {s_done, s_stop, s_pps, s_clk} = sync_b;
  assign tick_ev = s_clk & ~clk_dly;

  state_t           state;
  logic [TickW-1:0] tick_idx;
  logic [TickW-1:0] stop_tick_q;
  logic             stop_seen_q;
  logic             stop_err_q;
  logic             armed;
  logic             los_force;

  logic             fresh, chk_err, base_seen;
  logic [TickW-1:0] k_idx, base_tick, nxt_tick;
  logic             nxt_seen, nxt_err, missing, rpt_load;
  logic [TickW-1:0] new_ticks;
  logic [2:0]       new_err;

  // NOTE: every signal is assigned on every pass through this block, so no latch can be inferred.
  always_comb begin
    fresh     = s_pps;
    base_seen = fresh ? 1'b0 : stop_seen_q;
    base_tick = fresh ? '0 : stop_tick_q;
    k_idx     = fresh ? '0 : tick_idx + TickW'(1);
    // An armed check wants done without a new stop; unarmed, any done is a protocol error.
    chk_err   = armed ? (~s_done | s_stop) : s_done;
    nxt_seen  = base_seen | s_stop;
    nxt_tick  = (s_stop & ~base_seen) ? k_idx : base_tick;
    nxt_err   = (~fresh & stop_err_q) | chk_err | (s_stop & base_seen);
    missing   = ~s_pps && (tick_idx == TickLast);
    rpt_load  = tick_ev && (state == S_track) && (s_pps || missing);
    new_ticks = missing ? TicksFull : tick_idx + TickW'(1);
    new_err   = {stop_err_q, missing, ~missing && ((tick_idx + TickW'(1)) != TicksFull)};
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_tf) begin
    if (!tf_reset_l) begin
      sync_a        <= '0;
      sync_b        <= '0;
      clk_dly       <= 1'b0;
      state         <= S_hunt;
      tick_idx      <= '0;
      stop_tick_q   <= '0;
      stop_seen_q   <= 1'b0;
      stop_err_q    <= 1'b0;
      armed         <= 1'b0;
      rpt_valid     <= 1'b0;
      rpt_ticks     <= '0;
      rpt_stop_seen <= 1'b0;
      rpt_stop_tick <= '0;
      rpt_err       <= '0;
    end else begin
      sync_a  <= {uc_stop_done, uc_stop_next, uc_pps_next, uc_slow_clock};
      sync_b  <= sync_a;
      clk_dly <= s_clk;

      if (los_force) begin
        state <= S_hunt;
        armed <= 1'b0;
      end else if (tick_ev) begin
        if (state == S_track && missing) begin
          state <= S_hunt;
          armed <= 1'b0;
        end else if (state == S_track || s_pps) begin
          state       <= S_track;
          tick_idx    <= k_idx;
          stop_seen_q <= nxt_seen;
          stop_tick_q <= nxt_tick;
          stop_err_q  <= nxt_err;
          armed       <= s_stop;
        end
      end

      // A load while the old report is unaccepted overwrites it and flags the overrun.
      if (rpt_load) begin
        rpt_valid     <= 1'b1;
        rpt_ticks     <= new_ticks;
        rpt_stop_seen <= stop_seen_q;
        rpt_stop_tick <= stop_tick_q;
        rpt_err       <= {rpt_valid & ~rpt_ready, new_err};
      end else if (rpt_valid && rpt_ready) begin
        rpt_valid <= 1'b0;
      end
    end
  end

  assign locked = (state == S_track);

`ifdef UC_RX_LOS_EN
  localparam int WdW = $clog2(LosTimeout + 1);

  logic [WdW-1:0] wd_cnt;
  logic           los_q;

  assign los_force = ~tick_ev && (wd_cnt == WdW'(LosTimeout - 1));
  assign los       = los_q;

  always_ff @(posedge clk_tf) begin
    if (!tf_reset_l) begin
      wd_cnt <= '0;
      los_q  <= 1'b0;
    end else if (tick_ev) begin
      wd_cnt <= '0;
      los_q  <= 1'b0;
    end else if (wd_cnt != WdW'(LosTimeout)) begin
      wd_cnt <= wd_cnt + WdW'(1);
      if (los_force) los_q <= 1'b1;
    end
  end
`else
  assign los_force = 1'b0;
  assign los       = 1'b0;
`endif

endmodule

// File: doc/uc_timing_rx.md
# uc_timing_rx

Receiving end of the timing FPGA's microcontroller slow-clock interface (`uc_slow_clock`, `uc_pps_next`, `uc_stop_next`, `uc_stop_done`).

- Synchronizes the interface into `clk_tf` and detects slow-clock rising edges.
- Samples the three flags on each rising edge and tracks the slow-tick index within each second.
- Emits one per-second report through a valid/ready handshake: tick count, stop tick position, error flags.
- Used as the FPGA-side capture for a soft-core and as a synthesizable checker on the timing bench.

## Interface

Parameters:

- `SlowClocksPerSecond`, 10000: slow ticks expected between top-of-second (TOS) ticks.
- `TickW`, `$clog2(SlowClocksPerSecond+1)`: width of tick fields.
- `LosTimeout`, 3840: `clk_tf` cycles without a slow-clock rising edge before loss-of-signal is flagged. Used only with `UC_RX_LOS_EN`.

Ports:

- `clk_tf`  in  1  sole clock.
- `tf_reset_l`  in  1  reset; one clock; reset is synchronous and active-low.
- `uc_slow_clock`  in  1  slow clock, asynchronous to `clk_tf`.
- `uc_pps_next`  in  1  TOS flag, valid at slow-clock rise.
- `uc_stop_next`  in  1  TDC stop flag, valid at slow-clock rise.
- `uc_stop_done`  in  1  stop-done flag, valid at slow-clock rise.
- `rpt_valid`  out  1  report available.
- `rpt_ready`  in  1  consumer accepts the report.
- `rpt_ticks`  out  TickW  ticks counted in the completed second.
- `rpt_stop_seen`  out  1  a stop occurred in that second.
- `rpt_stop_tick`  out  TickW  tick index of the stop.
- `rpt_err`  out  4  error flags: [0] period, [1] missing TOS, [2] stop protocol, [3] overrun.
- `locked`  out  1  tracking state active.
- `los`  out  1  loss of slow clock. Tied 0 without `UC_RX_LOS_EN`.

## Operation

Capture path:

- All four inputs pass through an identical 2-flop synchronizer, then a third register for edge detection.
- Tick event = synchronized clock high while the delayed copy is low.
- Flags are taken from the synchronized stage in the tick-event cycle. They are held high until the slow-clock falling edge, so they are stable at that point.

Tick counting:

- A tick with `pps_next`=1 is the TOS tick and has index 0. Each following tick increments `tick_idx`.

States:

- `S_hunt` (reset state): waits for the first TOS tick, then goes to `S_track`. No report is produced for the partial second.
- `S_track`, TOS tick: emits a report with `rpt_ticks` = `tick_idx`+1 and restarts the index at 0.
  - `rpt_err[0]` is set if `rpt_ticks` ≠ `SlowClocksPerSecond`.
- `S_track`, missing TOS: a tick arrives with `tick_idx` = `SlowClocksPerSecond`-1 and `pps_next`=0.
  - Emits a report with `rpt_ticks` = `SlowClocksPerSecond` and `rpt_err[1]` set.
  - Returns to `S_hunt`.

Stop checking:

- `stop_next` at tick k records `rpt_stop_tick` = k and sets `stop_seen`, then arms a done check.
- The next tick must show `stop_done`=1 and `stop_next`=0.
- Any of the following sets `err[2]`:
  - `stop_done` without an armed check;
  - an armed check that fails;
  - a second `stop_next` in the same second.
- A stop on the last tick of a second arms a check that carries across the boundary. A failure of that check is charged to the new second.

Reporting:

- The report is a single-entry register. It is held stable while `rpt_valid`=1 and `rpt_ready`=0.
- A new report generated while the old one is unaccepted overwrites it and sets `err[3]`.
- A new report in the same cycle as a valid&&ready accept replaces the old report with `err[3]` clear, and `rpt_valid` stays 1.
- `locked` = (state == `S_track`).

## Timing

- Reset values: `rpt_valid`=0, all report fields 0, `locked`=0, `los`=0, state `S_hunt`, synchronizers 0.
- Reset is synchronous: taking effect mid-second or mid-handshake drops any pending report and returns to `S_hunt`.
- Latency:
  - Input rise to tick event: 3 `clk_tf` cycles.
  - TOS tick event to `rpt_valid`=1: 1 cycle (report registered).
  - `rpt_valid` falls 1 cycle after a valid&&ready accept, unless a new report is loaded.
- Minimum slow-clock high and low time is 3 `clk_tf` cycles. Shorter pulses are not guaranteed to be detected.
- Counters saturate at `SlowClocksPerSecond` and never wrap.

## Configuration

- Macro: `UC_RX_LOS_EN`.
- Defined:
  - A watchdog counts `clk_tf` cycles since the last tick event.
  - When the count reaches `LosTimeout`, `los`=1 and the state forces to `S_hunt` without emitting a report.
  - `los` clears on the next tick event.
- Undefined: no watchdog logic, `los` tied 0, and a stalled slow clock freezes the state.

## Test plan

Bench parameters: `SlowClocksPerSecond`=10, slow period 40 `clk_tf` cycles.

1. Clean run: TOS every 10 ticks, stop at tick 3, done at tick 4 → reports `ticks`=10, `stop_seen`=1, `stop_tick`=3, `err`=0. The first partial second produces no report.
2. Early TOS after 7 ticks → report `ticks`=7, `err[0]`=1, `locked` stays 1.
3. TOS withheld → report `ticks`=10, `err[1]`=1, `locked`=0. The next TOS relocks with no report.
4. Stop at tick 9 with done at tick 0 of the next second → clean. Done omitted instead → `err[2]`=1 in the next report. Double stop → `err[2]`=1.
5. `rpt_ready` held 0 across two seconds → second report has `err[3]`=1. `rpt_ready` pulsed in the load cycle → `err[3]`=0.
6. With `UC_RX_LOS_EN`: slow clock stopped for 3840 cycles → `los`=1, `locked`=0. Clock resumes → `los`=0 at the first tick event. Reset asserted mid-second → all outputs 0 the next cycle.
